// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matmul operand loader: default widths, the loader
// FSM state type and the (row, col, is_b) -> {bank, addr} tile mapping used to
// scatter operands across the per-bank BRAMs.
// -----------------------------------------------------------------------------
package matmul_pkg;

   localparam int unsigned DWIDTH_DEF = 16;
   localparam int unsigned AWIDTH_DEF = 10;

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StRun,
      StFinish
   } loader_state_t;

   typedef struct packed {
      logic [31:0] bank;
      logic [31:0] addr;
   } tile_loc_t;

   // A is split by column groups, B by row groups; each bank holds
   // MAT_DIM/NUM_BANKS consecutive elements per row (A) or per column (B).
   function automatic tile_loc_t tile_map(input int unsigned r,
                                          input int unsigned c,
                                          input logic        is_b,
                                          input int unsigned mat_dim,
                                          input int unsigned num_banks);
      int unsigned per_bank;
      tile_loc_t   loc;
      per_bank = mat_dim / num_banks;
      if (is_b) begin
         loc.bank = r / per_bank;
         loc.addr = c * per_bank + r % per_bank;
      end else begin
         loc.bank = c / per_bank;
         loc.addr = r * per_bank + c % per_bank;
      end
      return loc;
   endfunction

endpackage

// File: rtl/matmul_operand_loader_tile_index_counter.sv
// -----------------------------------------------------------------------------
// tile_index_counter
// Row/column counter walking a MAT_DIM x MAT_DIM matrix in row-major order.
//   clk, resetn : clock, async active-low reset
//   inc         : advance one element (column inner, row outer)
//   clr         : synchronous clear, wins over inc
//   r, c        : current row / column
//   last        : r == c == MAT_DIM-1; the next inc wraps both to zero
// -----------------------------------------------------------------------------
module tile_index_counter #(
   parameter  int unsigned MAT_DIM = 16,
   localparam int unsigned LW      = $clog2(MAT_DIM)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          inc,
   input  logic          clr,
   output logic [LW-1:0] r,
   output logic [LW-1:0] c,
   output logic          last
);

   localparam logic [LW-1:0] Max = LW'(MAT_DIM - 1);

   logic [LW-1:0] r_q, r_d, c_q, c_d;

   always_comb begin
      r_d = r_q;
      c_d = c_q;
      if (clr) begin
         r_d = '0;
         c_d = '0;
      end else if (inc) begin
         if (c_q == Max) begin
            c_d = '0;
            r_d = (r_q == Max) ? '0 : r_q + LW'(1);
         end else begin
            c_d = c_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q <= '0;
         c_q <= '0;
      end else begin
         r_q <= r_d;
         c_q <= c_d;
      end
   end

   assign r    = r_q;
   assign c    = c_q;
   assign last = (r_q == Max) && (c_q == Max);

endmodule

// File: rtl/matmul_operand_loader.sv
// -----------------------------------------------------------------------------
// matmul_operand_loader
// Accepts a valid/ready stream of A then B (both row-major), scatters them into
// the per-bank operand BRAMs, then holds mm_start until mm_done.
//   clk, resetn            : clock, async active-low reset
//   load_go                : start a pass (sampled in idle only)
//   in_valid/in_ready/in_data : operand element stream
//   a_we/a_addr/a_wdata    : registered one-hot write port, A banks
//   b_we/b_addr/b_wdata    : registered one-hot write port, B banks
//   mm_start, mm_done      : compute block handshake
//   busy                   : any state other than idle
//   load_done              : one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module matmul_operand_loader
   import matmul_pkg::*;
#(
   parameter int unsigned DWIDTH    = DWIDTH_DEF,
   parameter int unsigned AWIDTH    = AWIDTH_DEF,
   parameter int unsigned MAT_DIM   = 16,
   parameter int unsigned NUM_BANKS = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 load_go,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DWIDTH-1:0]    in_data,
   output logic [NUM_BANKS-1:0] a_we,
   output logic [AWIDTH-1:0]    a_addr,
   output logic [DWIDTH-1:0]    a_wdata,
   output logic [NUM_BANKS-1:0] b_we,
   output logic [AWIDTH-1:0]    b_addr,
   output logic [DWIDTH-1:0]    b_wdata,
   output logic                 mm_start,
   input  logic                 mm_done,
   output logic                 busy,
   output logic                 load_done
);

   localparam int unsigned LW = $clog2(MAT_DIM);

   loader_state_t          state_q, state_d;
   logic                   in_ready_q;
   logic [LW-1:0]          cnt_r, cnt_c;
   logic                   cnt_last;
   logic                   accept;
   tile_loc_t              loc;
   logic [NUM_BANKS-1:0]   we_d;
   logic [AWIDTH-1:0]      waddr_d;
   logic [NUM_BANKS-1:0]   a_we_q, b_we_q;
   logic [AWIDTH-1:0]      a_addr_q, b_addr_q;
   logic [DWIDTH-1:0]      a_wdata_q, b_wdata_q;

   assign accept = in_valid && in_ready_q;

   // Cleared while idle so every pass starts at element (0, 0).
   tile_index_counter #(
      .MAT_DIM (MAT_DIM)
   ) u_tile_index_counter (
      .clk    (clk),
      .resetn (resetn),
      .inc    (accept),
      .clr    (state_q == StIdle),
      .r      (cnt_r),
      .c      (cnt_c),
      .last   (cnt_last)
   );

   always_comb begin
      loc     = tile_map(32'(cnt_r), 32'(cnt_c), state_q == StLoadB, MAT_DIM, NUM_BANKS);
      we_d    = NUM_BANKS'(1) << loc.bank;
      waddr_d = AWIDTH'(loc.addr);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (load_go) state_d = StLoadA;
         StLoadA:  if (accept && cnt_last) state_d = StLoadB;
         StLoadB:  if (accept && cnt_last) state_d = StRun;
         StRun:    if (mm_done) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         in_ready_q <= 1'b0;
         a_we_q     <= '0;
         a_addr_q   <= '0;
         a_wdata_q  <= '0;
         b_we_q     <= '0;
         b_addr_q   <= '0;
         b_wdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         // Decoded from the next state so ready stays high across A->B.
         in_ready_q <= (state_d == StLoadA) || (state_d == StLoadB);
         a_we_q     <= '0;
         b_we_q     <= '0;
         if (accept && (state_q == StLoadA)) begin
            a_we_q    <= we_d;
            a_addr_q  <= waddr_d;
            a_wdata_q <= in_data;
         end
         if (accept && (state_q == StLoadB)) begin
            b_we_q    <= we_d;
            b_addr_q  <= waddr_d;
            b_wdata_q <= in_data;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign a_we      = a_we_q;
   assign a_addr    = a_addr_q;
   assign a_wdata   = a_wdata_q;
   assign b_we      = b_we_q;
   assign b_addr    = b_addr_q;
   assign b_wdata   = b_wdata_q;
   assign mm_start  = (state_q == StRun);
   assign busy      = (state_q != StIdle);
   assign load_done = (state_q == StFinish);

endmodule

// File: tb/tb_matmul_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_matmul_operand_loader
// Randomised stimulus against an element-index model of the loader; every
// output is compared each cycle, with literal pins on the mapping and timing.
// -----------------------------------------------------------------------------
module tb_matmul_operand_loader;
   import matmul_pkg::*;

   localparam int MD = 16;
   localparam int NB = 4;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int NE = MD * MD;
   localparam int TPB = MD / NB;

   localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FIN = 3;
   localparam int MODE_ONES = 0, MODE_IDX = 1, MODE_RND = 2;

   logic          clk, resetn, load_go, in_valid, in_ready, mm_start, mm_done;
   logic          busy, load_done;
   logic [DW-1:0] in_data, a_wdata, b_wdata;
   logic [NB-1:0] a_we, b_we;
   logic [AW-1:0] a_addr, b_addr;

   matmul_operand_loader #(
      .DWIDTH    (DW),
      .AWIDTH    (AW),
      .MAT_DIM   (MD),
      .NUM_BANKS (NB)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .load_go   (load_go),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .mm_start  (mm_start),
      .mm_done   (mm_done),
      .busy      (busy),
      .load_done (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp, n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Element index 0..NE-1 is A, NE..2*NE-1 is B; both row-major.
   function automatic int exp_bank(input int idx);
      int e, r, c;
      e = idx % NE; r = e / MD; c = e % MD;
      return (idx < NE) ? c / TPB : r / TPB;
   endfunction

   function automatic int exp_addr(input int idx);
      int e, r, c;
      e = idx % NE; r = e / MD; c = e % MD;
      return (idx < NE) ? r * TPB + c % TPB : c * TPB + r % TPB;
   endfunction

   // ---------------- behavioural model ----------------
   int            m_phase, m_n;
   logic [NB-1:0] e_a_we, e_b_we;
   logic [AW-1:0] e_a_addr, e_b_addr;
   logic [DW-1:0] e_a_wdata, e_b_wdata;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_phase <= P_IDLE; m_n <= 0;
         e_a_we <= '0; e_a_addr <= '0; e_a_wdata <= '0;
         e_b_we <= '0; e_b_addr <= '0; e_b_wdata <= '0;
      end else begin
         e_a_we <= '0;
         e_b_we <= '0;
         case (m_phase)
            P_IDLE: if (load_go) m_phase <= P_LOAD;
            P_LOAD: if (in_valid) begin
               if (m_n < NE) begin
                  e_a_we    <= NB'(1) << exp_bank(m_n);
                  e_a_addr  <= AW'(exp_addr(m_n));
                  e_a_wdata <= in_data;
               end else begin
                  e_b_we    <= NB'(1) << exp_bank(m_n);
                  e_b_addr  <= AW'(exp_addr(m_n));
                  e_b_wdata <= in_data;
               end
               if (m_n == 2 * NE - 1) begin
                  m_n <= 0; m_phase <= P_RUN;
               end else begin
                  m_n <= m_n + 1;
               end
            end
            P_RUN:   if (mm_done) m_phase <= P_FIN;
            default: m_phase <= P_IDLE;
         endcase
      end
   end

   // ---------------- per-pass observation ----------------
   int          pass_mode, cyc, start_cycle, ld_cnt, n_wr, hit18, hit37;
   logic        s_start;
   int          a_cnt [NB];
   int          b_cnt [NB];
   logic [63:0] a_seen [NB];
   logic [63:0] b_seen [NB];

   task automatic clear_pass();
      cyc = 0; start_cycle = 0; ld_cnt = 0; n_wr = 0; hit18 = 0; hit37 = 0;
      for (int b = 0; b < NB; b++) begin
         a_cnt[b] = 0; b_cnt[b] = 0; a_seen[b] = '0; b_seen[b] = '0;
      end
   endtask

   // Compare everything at the falling edge, then return just after the rising edge.
   task automatic tick(output bit acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc++;
      chk("in_ready",  32'(in_ready),  32'(m_phase == P_LOAD));
      chk("busy",      32'(busy),      32'(m_phase != P_IDLE));
      chk("mm_start",  32'(mm_start),  32'(m_phase == P_RUN));
      chk("load_done", 32'(load_done), 32'(m_phase == P_FIN));
      chk("a_we",    32'(a_we),    32'(e_a_we));
      chk("a_addr",  32'(a_addr),  32'(e_a_addr));
      chk("a_wdata", 32'(a_wdata), 32'(e_a_wdata));
      chk("b_we",    32'(b_we),    32'(e_b_we));
      chk("b_addr",  32'(b_addr),  32'(e_b_addr));
      chk("b_wdata", 32'(b_wdata), 32'(e_b_wdata));
      for (int b = 0; b < NB; b++) begin
         if (a_we[b]) begin a_cnt[b]++; a_seen[b][a_addr[5:0]] = 1'b1; end
         if (b_we[b]) begin b_cnt[b]++; b_seen[b][b_addr[5:0]] = 1'b1; end
      end
      if (a_we != '0) n_wr++;
      if (b_we != '0) n_wr++;
      if (pass_mode == MODE_IDX && a_we != '0 && a_wdata == 18) begin
         hit18++;
         chk("a_idx18_we", 32'(a_we), 32'h1);
         chk("a_idx18_addr", 32'(a_addr), 32'd6);
      end
      if (pass_mode == MODE_IDX && b_we != '0 && b_wdata == 37) begin
         hit37++;
         chk("b_idx37_we", 32'(b_we), 32'h1);
         chk("b_idx37_addr", 32'(b_addr), 32'd22);
      end
      if (mm_start && start_cycle == 0) start_cycle = cyc;
      if (load_done) ld_cnt++;
      s_start = mm_start;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] data_of(input int mode, input int n);
      if (mode == MODE_ONES) return DW'(1);
      if (mode == MODE_IDX) return DW'(n % NE);
      return DW'($urandom);
   endfunction

   // One pass; load_go is driven in cycle 1 of the pass.
   task automatic do_pass(input int pct, input int mode, input int abort_at,
                          input int hold, input bit go_in_run);
      bit acc;
      int sent, guard;
      bit got;
      pass_mode = mode;
      clear_pass();
      sent = 0; guard = 0;
      load_go = 1'b1;
      while (sent < 2 * NE && guard < 8000) begin
         in_valid = (pct >= 100) || ($urandom_range(99) < pct);
         in_data  = data_of(mode, sent);
         tick(acc);
         load_go = 1'b0;
         if (acc) sent++;
         guard++;
         if (abort_at != 0 && sent == abort_at) break;
      end
      in_valid = 1'b0;
      if (abort_at != 0) return;
      chk("all_accepted", 32'(sent), 32'(2 * NE));
      guard = 0; got = 1'b0;
      while (!got && guard < 50) begin
         tick(acc);
         got = s_start;
         guard++;
      end
      chk("start_seen", 32'(got), 32'd1);
      load_go = go_in_run;
      repeat (hold) tick(acc);
      chk("start_held", 32'(s_start), 32'd1);
      load_go = 1'b0;
      mm_done = 1'b1;
      tick(acc);
      mm_done = 1'b0;
      repeat (2) tick(acc);
      chk("load_done_pulses", 32'(ld_cnt), 32'd1);
   endtask

   task automatic reset_phase(input int cycles);
      bit acc;
      resetn = 1'b0;
      repeat (cycles) begin
         load_go  = 1'($urandom);
         in_valid = 1'($urandom);
         mm_done  = 1'($urandom);
         in_data  = DW'($urandom);
         tick(acc);
      end
      load_go = 1'b0; in_valid = 1'b0; mm_done = 1'b0; in_data = '0;
      resetn = 1'b1;
      tick(acc);
   endtask

   tile_loc_t pin_loc;

   initial begin
      n_cmp = 0; n_err = 0; pass_mode = MODE_ONES;
      resetn = 1'b0; load_go = 1'b0; in_valid = 1'b0; in_data = '0; mm_done = 1'b0;
      clear_pass();

      // Pin the shared mapping function and the model against hand values.
      pin_loc = tile_map(1, 2, 1'b0, MD, NB);
      chk("pkg_a_bank", pin_loc.bank, 32'd0);
      chk("pkg_a_addr", pin_loc.addr, 32'd6);
      pin_loc = tile_map(2, 5, 1'b1, MD, NB);
      chk("pkg_b_bank", pin_loc.bank, 32'd0);
      chk("pkg_b_addr", pin_loc.addr, 32'd22);
      chk("model_a18_addr", 32'(exp_addr(18)), 32'd6);
      chk("model_b37_addr", 32'(exp_addr(NE + 37)), 32'd22);
      chk("model_a_r3c13_bank", 32'(exp_bank(3 * 16 + 13)), 32'd3);
      chk("model_b_r5c3_bank", 32'(exp_bank(NE + 5 * 16 + 3)), 32'd1);
      chk("model_b_r5c3_addr", 32'(exp_addr(NE + 5 * 16 + 3)), 32'd13);

      // Reset held with all inputs toggling.
      reset_phase(16);

      // All-ones, no stalls, long compute with load_go poked during RUN.
      do_pass(100, MODE_ONES, 0, 200, 1'b1);
      // mm_start first high in cycle 514, counting the load_go cycle as cycle 1.
      chk("start_cycle", 32'(start_cycle), 32'd514);
      for (int b = 0; b < NB; b++) begin
         chk("a_bank_writes", 32'(a_cnt[b]), 32'd64);
         chk("b_bank_writes", 32'(b_cnt[b]), 32'd64);
         chk("a_bank_addrs_lo", a_seen[b][31:0], 32'hffff_ffff);
         chk("a_bank_addrs_hi", a_seen[b][63:32], 32'hffff_ffff);
         chk("b_bank_addrs_lo", b_seen[b][31:0], 32'hffff_ffff);
         chk("b_bank_addrs_hi", b_seen[b][63:32], 32'hffff_ffff);
      end

      // Index-valued data, no stalls.
      do_pass(100, MODE_IDX, 0, 3, 1'b0);
      chk("hit_a18", 32'(hit18), 32'd1);
      chk("hit_b37", 32'(hit37), 32'd1);

      // Index-valued data with 50% valid.
      do_pass(50, MODE_IDX, 0, 1, 1'b0);
      chk("bp_write_count", 32'(n_wr), 32'(2 * NE));
      chk("bp_hit_a18", 32'(hit18), 32'd1);

      // Abort after 100 elements, then a fresh pass.
      do_pass(100, MODE_IDX, 100, 0, 1'b0);
      reset_phase(6);
      do_pass(70, MODE_RND, 0, 5, 1'b0);
      chk("after_abort_writes", 32'(n_wr), 32'(2 * NE));

      // Back-to-back passes.
      do_pass(100, MODE_RND, 0, 0, 1'b0);
      do_pass(100, MODE_RND, 0, 2, 1'b0);
      chk("b2b_writes", 32'(n_wr), 32'(2 * NE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
